// File: rtl/updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for updown_counter and its optional prescaler.
//   MODE_WRAP / MODE_SAT : values for the MODE parameter of updown_counter
//   action_e             : what the counter does on a given edge
//   pick_action()        : resolves the per-edge priority clr > load > step > hold
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        STEP = 2'd1,
        LOAD = 2'd2,
        CLR  = 2'd3
    } action_e;

    function automatic action_e pick_action(input logic clr,
                                            input logic load,
                                            input logic step_ok);
        action_e act;
        if (clr) begin
            act = CLR;
        end else if (load) begin
            act = LOAD;
        end else if (step_ok) begin
            act = STEP;
        end else begin
            act = HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/updown_counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
// Divides the enabled cycles of updown_counter by PRESCALE. The internal
// divider only advances while en=1 and raises tick on every PRESCALE-th
// enabled cycle. restart forces the divider back to the start of a period.
//   clk     : clock, rising edge active
//   rst     : asynchronous active-high reset (divider -> 0)
//   en      : advance enable
//   restart : synchronous return to start of period (higher priority than en)
//   tick    : combinational, high on the last enabled cycle of a period
// -----------------------------------------------------------------------------
module counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    // PRESCALE=1 still needs a one-bit counter; it simply never leaves 0.
    localparam int              CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;

    always_comb begin
        tick  = en && (div_q == LAST);
        div_d = div_q;
        if (restart) begin
            div_d = '0;
        end else if (en) begin
            div_d = (div_q == LAST) ? '0 : div_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
// Modulo-MODULO up/down counter with synchronous clear and load, wrap or
// saturate boundary behaviour and a registered terminal-count pulse.
// Optional build macro UPDOWN_COUNTER_PRESCALE_EN inserts a PRESCALE-cycle
// divider (counter_prescaler) so that steps occur only on divider ticks.
//   clk      : clock, rising edge active
//   rst      : asynchronous active-high reset (count, tc, divider -> 0)
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous load of min(load_val, MODULO-1)
//   load_val : value for load
//   clr      : synchronous clear to 0 (highest priority)
//   count    : registered counter value
//   tc       : registered pulse, high the cycle after a step attempted at the
//              directional boundary
// -----------------------------------------------------------------------------
module updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULO   = 16,
    parameter int              MODE     = 0,
    parameter int              PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Computed in 64 bits before truncation, so MODULO = 2^WIDTH yields an
    // all-ones maximum instead of overflowing.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             step_ok;
    action_e          action;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    logic tick;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (clr | load),
        .tick    (tick)
    );

    assign step_ok = tick;
`else
    // Every enabled cycle is a step; PRESCALE is meaningless in this build
    // and only appears here as an always-true qualifier.
    assign step_ok = en & (PRESCALE >= 1);
`endif

    always_comb begin
        action  = pick_action(clr, load, step_ok);
        count_d = count_q;
        tc_d    = 1'b0;
        case (action)
            CLR: begin
                count_d = '0;
            end
            LOAD: begin
                count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            end
            STEP: begin
                if (up) begin
                    // Equality test before the increment keeps the sum
                    // inside WIDTH bits.
                    if (count_q == MAX_VAL) begin
                        tc_d    = 1'b1;
                        count_d = (MODE == MODE_SAT) ? MAX_VAL : '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        tc_d    = 1'b1;
                        count_d = (MODE == MODE_SAT) ? '0 : MAX_VAL;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_counter
// Three counters share one stimulus stream:
//   k=0 : WIDTH 4, MODULO 10, wrap
//   k=1 : WIDTH 4, MODULO 10, saturate
//   k=2 : WIDTH 4, MODULO 16, wrap (full-range arithmetic)
// A small arithmetic model predicts count/tc for each. Honours
// UPDOWN_COUNTER_PRESCALE_EN with a PRESCALE=4 divider model.
// -----------------------------------------------------------------------------
module tb_updown_counter;

    localparam int PS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic       clr;
    logic [3:0] load_val;

    logic [3:0] cnt0, cnt1, cnt2;
    logic       tc0, tc1, tc2;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int mods [3];
    bit sats [3];
    int m_c  [3];
    bit m_t  [3];
    int pdiv;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .MODULO(10), .MODE(0), .PRESCALE(PS)) dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr(clr), .count(cnt0), .tc(tc0)
    );
    updown_counter #(.WIDTH(4), .MODULO(10), .MODE(1), .PRESCALE(PS)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr(clr), .count(cnt1), .tc(tc1)
    );
    updown_counter #(.WIDTH(4), .MODULO(16), .MODE(0), .PRESCALE(PS)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr(clr), .count(cnt2), .tc(tc2)
    );

    function automatic logic [31:0] get_cnt(input int k);
        case (k)
            0:       return {28'd0, cnt0};
            1:       return {28'd0, cnt1};
            default: return {28'd0, cnt2};
        endcase
    endfunction

    function automatic logic [31:0] get_tc(input int k);
        case (k)
            0:       return {31'd0, tc0};
            1:       return {31'd0, tc1};
            default: return {31'd0, tc2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(input string ctx);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s count[%0d]", ctx, k), get_cnt(k), 32'(m_c[k]));
            check($sformatf("%s tc[%0d]", ctx, k), get_tc(k), {31'd0, m_t[k]});
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_c[k] = 0;
            m_t[k] = 1'b0;
        end
        pdiv = 0;
    endtask

    // Reference behaviour at one rising edge, using the inputs present there.
    task automatic model_edge();
        bit tick;
        int lv;
        if (rst) begin
            model_reset();
            return;
        end
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        tick = en && (pdiv == PS - 1);
        if (clr || load)  pdiv = 0;
        else if (en)      pdiv = (pdiv + 1) % PS;
`else
        tick = en;
`endif
        lv = int'(load_val);
        for (int k = 0; k < 3; k++) begin
            if (clr) begin
                m_c[k] = 0;
                m_t[k] = 1'b0;
            end else if (load) begin
                m_c[k] = (lv < mods[k] - 1) ? lv : mods[k] - 1;
                m_t[k] = 1'b0;
            end else if (tick && up) begin
                m_t[k] = (m_c[k] == mods[k] - 1);
                if (sats[k]) m_c[k] = (m_c[k] + 1 > mods[k] - 1) ? mods[k] - 1 : m_c[k] + 1;
                else         m_c[k] = (m_c[k] + 1) % mods[k];
            end else if (tick && !up) begin
                m_t[k] = (m_c[k] == 0);
                if (sats[k]) m_c[k] = (m_c[k] - 1 < 0) ? 0 : m_c[k] - 1;
                else         m_c[k] = (m_c[k] + mods[k] - 1) % mods[k];
            end else begin
                m_t[k] = 1'b0;
            end
        end
    endtask

    // One clock: model updates on the rising edge, outputs checked at the
    // falling edge. Inputs are changed by the caller afterwards.
    task automatic clk_cycle(input string ctx);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        $display("cyc %0d %s rst=%0b clr=%0b load=%0b lv=%0d en=%0b up=%0b | count %0d/%0d/%0d tc %0b/%0b/%0b",
                 cyc, ctx, rst, clr, load, load_val, en, up, cnt0, cnt1, cnt2, tc0, tc1, tc2);
        check_all(ctx);
    endtask

    task automatic set_in(input bit i_en, input bit i_up, input bit i_load,
                          input int i_lv, input bit i_clr);
        en       = i_en;
        up       = i_up;
        load     = i_load;
        load_val = 4'(i_lv);
        clr      = i_clr;
    endtask

    initial begin
        int exp_seq [12];
        mods[0] = 10; mods[1] = 10; mods[2] = 16;
        sats[0] = 1'b0; sats[1] = 1'b1; sats[2] = 1'b0;
        exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        #20;
        check_all("reset");
        rst = 1'b0;

        // Count up 12 cycles from 0.
        set_in(1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            clk_cycle("up12");
`ifndef UPDOWN_COUNTER_PRESCALE_EN
            check("up12 const count", {28'd0, cnt0}, 32'(exp_seq[i]));
            check("up12 const tc", {31'd0, tc0}, (i == 9) ? 32'd1 : 32'd0);
`endif
        end

        // Load 3 then count down 5: 2,1,0,9,8.
        set_in(0, 0, 1, 3, 0);
        clk_cycle("load3");
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) clk_cycle("down5");
`ifndef UPDOWN_COUNTER_PRESCALE_EN
        check("down5 const count", {28'd0, cnt0}, 32'd8);
`endif
        // Oversized load clamps to MODULO-1.
        set_in(0, 0, 1, 15, 0);
        clk_cycle("load15");
        check("load15 const count", {28'd0, cnt0}, 32'd9);
        check("load15 full-range count", {28'd0, cnt2}, 32'd15);

        // Saturation at top, then at bottom.
        set_in(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            clk_cycle("sat_top");
`ifndef UPDOWN_COUNTER_PRESCALE_EN
            check("sat_top const count", {28'd0, cnt1}, 32'd9);
            check("sat_top const tc", {31'd0, tc1}, 32'd1);
`endif
        end
        set_in(0, 0, 1, 0, 0);
        clk_cycle("load0");
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) clk_cycle("sat_bot");

        // Priority: clr over load over step.
        set_in(0, 0, 1, 5, 0);
        clk_cycle("load5");
        set_in(1, 1, 1, 5, 1);
        clk_cycle("clr_load_en");
        check("clr wins const", {28'd0, cnt0}, 32'd0);
        set_in(1, 1, 1, 3, 0);
        clk_cycle("load_en");
        check("load wins const", {28'd0, cnt0}, 32'd3);

        // Asynchronous reset mid-cycle at count 7.
        set_in(0, 0, 1, 7, 0);
        clk_cycle("load7");
        set_in(1, 1, 0, 0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        check_all("rst_held");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) clk_cycle("resume");

        // Restart of the divider by load mid-period, then plain counting.
        set_in(0, 1, 1, 2, 0);
        clk_cycle("load_mid");
        set_in(1, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) clk_cycle("en16");

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            set_in($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)),
                   $urandom_range(0, 29) == 0);
            clk_cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
